// File: rtl/pix_tx_buffer_if.sv
// rtl/pix_tx_buffer_if.sv - pixel write and UART transmit handshake bundle
interface pix_tx_buffer_if #(
  parameter int D_BITS = 8
);
  logic              i_wr;
  logic [D_BITS-1:0] i_data;
  logic              i_tx_rdy;
  logic [D_BITS-1:0] o_data;
  logic              o_tx_enable;

  modport slave (
    input  i_wr, i_data, i_tx_rdy,
    output o_data, o_tx_enable
  );

  modport master (
    output i_wr, i_data, i_tx_rdy,
    input  o_data, o_tx_enable
  );
endinterface

// File: rtl/pix_tx_buffer.sv
// rtl/pix_tx_buffer.sv - pixel FIFO draining byte-serially to a UART transmitter
// Stream mode forwards immediately; frame mode stores a whole frame before sending.
module pix_tx_buffer #(
  parameter int D_BITS = 8,
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  reset,
  input  logic                  i_mode,
  input  logic [31:0]           i_frame_len,
  pix_tx_buffer_if.slave        bus,
  output logic [AW:0]           o_level,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_overflow,
  output logic                  o_frame_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT_BUSY,
    S_WAIT_RDY
  } state_t;

  localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);

  state_t            state_q, state_d;
  logic [D_BITS-1:0] mem_q [DEPTH];
  logic [D_BITS-1:0] rd_data_q;
  logic [D_BITS-1:0] tx_data_q, tx_data_d;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       level_q, level_d;
  logic              overflow_q, frame_done_q;
  logic              draining_q, draining_d;
  logic              mode_q;
  logic [31:0]       flen_q, wr_cnt_q, wr_cnt_d, tx_cnt_q, tx_cnt_d;

  logic              full, empty, cfg_open, mode_eff, count_en, drain_ok;
  logic [31:0]       flen_eff;
  logic              rd_en, wr_en, wr_drop, tx_en, frame_end;

  assign full  = (level_q == LEVEL_FULL);
  assign empty = (level_q == '0);

  // Configuration follows the inputs only while no frame is in flight.
  assign cfg_open = (wr_cnt_q == 32'd0) && (tx_cnt_q == 32'd0);
  assign mode_eff = cfg_open ? i_mode : mode_q;
  assign flen_eff = cfg_open ? i_frame_len : flen_q;
  assign count_en = (flen_eff != 32'd0);

  // Full also grants permission so frames longer than the FIFO cannot deadlock.
  assign drain_ok = !empty && (!mode_eff || !count_en || (wr_cnt_q >= flen_eff) ||
                               full || draining_q);

  always_comb begin
    state_d   = state_q;
    rd_en     = 1'b0;
    tx_en     = 1'b0;
    frame_end = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (drain_ok && bus.i_tx_rdy) begin
          rd_en   = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD:  state_d = S_SEND;
      S_SEND: begin
        tx_en   = 1'b1;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!bus.i_tx_rdy) state_d = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (bus.i_tx_rdy) begin
          frame_end = count_en && (tx_cnt_q == flen_eff);
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign wr_en   = bus.i_wr && (!full || rd_en);
  assign wr_drop = bus.i_wr && full && !rd_en;

  always_comb begin
    level_d    = level_q;
    tx_data_d  = tx_data_q;
    wr_cnt_d   = wr_cnt_q;
    tx_cnt_d   = tx_cnt_q;
    draining_d = draining_q;
    unique case ({wr_en, rd_en})
      2'b10:   level_d = level_q + (AW + 1)'(1);
      2'b01:   level_d = level_q - (AW + 1)'(1);
      default: level_d = level_q;
    endcase
    if (state_q == S_LOAD) tx_data_d = rd_data_q;
    // Overlapping writes carry into the next frame rather than being cleared.
    if (frame_end) wr_cnt_d = wr_cnt_q - flen_eff;
    if (wr_en && count_en) wr_cnt_d = wr_cnt_d + 32'd1;
    if (frame_end) begin
      tx_cnt_d   = 32'd0;
      draining_d = 1'b0;
    end else begin
      if (tx_en && count_en) tx_cnt_d = tx_cnt_q + 32'd1;
      if (rd_en && count_en) draining_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.i_data;
    if (rd_en) rd_data_q <= mem_q[rd_ptr_q];
  end

  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      tx_data_q    <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
      draining_q   <= 1'b0;
      mode_q       <= 1'b0;
      flen_q       <= 32'd0;
      wr_cnt_q     <= 32'd0;
      tx_cnt_q     <= 32'd0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      tx_data_q    <= tx_data_d;
      overflow_q   <= overflow_q | wr_drop;
      frame_done_q <= frame_end;
      draining_q   <= draining_d;
      wr_cnt_q     <= wr_cnt_d;
      tx_cnt_q     <= tx_cnt_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (cfg_open) begin
        mode_q <= i_mode;
        flen_q <= i_frame_len;
      end
    end
  end

  assign bus.o_data      = tx_data_q;
  assign bus.o_tx_enable = tx_en;
  assign o_level         = level_q;
  assign o_full          = full;
  assign o_empty         = empty;
  assign o_overflow      = overflow_q;
  assign o_frame_done    = frame_done_q;

endmodule
